sprite_anim_ctrl: RTL and testbench
===================================

// Module: sprite_anim_ctrl
// PURPOSE
// Sequences animation state for one collectable sprite channel and the life-heart icon.
// Drives the s_type/frame inputs of the collectable sprite ROM and the frame input of the heart ROM.
// Sprite lifecycle: spawn, swim-cycle animation, collect pose, despawn; all timing counted in video frames (vsync).
// Sits between game logic (spawn/collect/hit events) and the sprite ROM pixel lookups.
// PARAMETERS
// LOG_FRAMES     3   width of sprite frame index
// SWIM_FRAMES    4   swim cycle length; frames 0..SWIM_FRAMES-1 (<= 2**LOG_FRAMES)
// TICKS_PER_FRM  6   vsync pulses per swim frame step (>=1)
// COLLECT_FRAME  4   frame index held during collect pose
// COLLECT_TICKS  20  vsync pulses collect pose is shown (>=1)
// BLINK_TICKS    8   vsync pulses between heart_frame toggles (>=1)
// BLINK_TOGGLES  6   toggles per hit blink; even, so the blink ends on heart_frame=0
// PORTS
// clock        in   1           system clock
// reset        in   1           asynchronous, active-high
// vsync_pulse  in   1           one-cycle pulse at start of each video frame
// spawn        in   1           pulse: start sprite with spawn_type
// spawn_type   in   3           sprite type latched on accepted spawn (1 = coin)
// collect      in   1           pulse: player collected sprite
// despawn      in   1           pulse: sprite left screen, kill immediately
// hit          in   1           pulse: player lost a life, start heart blink
// s_type       out  3           sprite type to ROM (0 = none)
// frame        out  LOG_FRAMES  sprite frame index to ROM
// active       out  1           sprite visible (state != IDLE)
// collecting   out  1           state == COLLECT
// heart_frame  out  1           heart ROM frame (0 = full, 1 = outline)
// blinking     out  1           heart blink in progress
// BEHAVIOUR
// Single clock domain; one clock only. Reset: async, active-high.
// All outputs registered; they update on the clock edge after the causing input. Reset value of all outputs is 0.
// Sprite FSM, states IDLE, SWIM, COLLECT; tick_cnt counts vsync pulses within a step.
//  IDLE: s_type=0, frame=0. On spawn -> SWIM: s_type<=spawn_type, frame<=0, tick_cnt<=0.
//  SWIM: on vsync_pulse tick_cnt++. At tick_cnt==TICKS_PER_FRM-1: tick_cnt<=0, frame<=frame+1, wrapping SWIM_FRAMES-1 -> 0.
//   On collect -> COLLECT: frame<=COLLECT_FRAME, tick_cnt<=0.
//  COLLECT: on vsync_pulse tick_cnt++. At tick_cnt==COLLECT_TICKS-1 -> IDLE, s_type<=0, frame<=0.
//  despawn in SWIM or COLLECT -> IDLE next edge.
// Priority, same cycle: despawn > collect > vsync tick > spawn.
//  collect + vsync_pulse: the tick is discarded; the COLLECT count starts at 0.
//  spawn in SWIM or COLLECT is ignored; no queueing.
//  collect in IDLE or COLLECT is ignored.
//  A spawn in the same cycle as a COLLECT->IDLE exit is ignored.
// Heart blink: blink_cnt counts remaining toggles.
//  On hit: blink_cnt<=BLINK_TOGGLES, tick_cnt_h<=0, heart_frame<=1, blinking<=1.
//   A hit during a blink restarts it with the same values.
//  While blinking, each vsync_pulse increments tick_cnt_h. At BLINK_TICKS-1: tick_cnt_h<=0, heart_frame toggles, blink_cnt--.
//  When blink_cnt reaches 0: blinking<=0 and heart_frame==0.
//  hit + vsync_pulse in the same cycle: hit wins.
//  The heart channel is independent of the sprite FSM.
// Reset mid-operation: all state returns to IDLE / not blinking asynchronously; counters cleared.
// Counter widths: $clog2 of the largest terminal value + 1. No overflow is possible by construction.
// TESTING
// 1. reset held, random pulses -> all outputs 0. Release reset, no events -> outputs stay 0.
// 2. spawn, spawn_type=1 -> s_type=1, frame=0, active=1.
//    Then 6 vsyncs -> frame=1; 24 vsyncs total -> frame wraps to 0.
// 3. In SWIM at frame=2, collect -> frame=4, collecting=1.
//    19 vsyncs -> still COLLECT; 20th vsync -> s_type=0, active=0.
// 4. collect+despawn same cycle -> IDLE.
//    spawn during COLLECT -> ignored, s_type unchanged.
//    collect+vsync same cycle -> COLLECT count starts at 0 (20 more vsyncs to exit).
// 5. hit -> heart_frame=1, blinking=1; toggles every 8 vsyncs.
//    After 48 vsyncs -> blinking=0, heart_frame=0. Second hit at vsync 20 -> blink restarts and ends 48 vsyncs after that hit.
// 6. Async reset asserted mid-COLLECT and mid-blink, between clock edges -> outputs 0 immediately.
//    After release, the next spawn behaves as in test 2.

Source files
------------

// File: rtl/sprite_anim_ctrl.sv
// Animation sequencer for one collectable sprite channel plus the life-heart blink.
// Everything advances on vsync pulses; every output is a flop.
module sprite_anim_ctrl #(
    parameter int LOG_FRAMES    = 3,
    parameter int SWIM_FRAMES   = 4,
    parameter int TICKS_PER_FRM = 6,
    parameter int COLLECT_FRAME = 4,
    parameter int COLLECT_TICKS = 20,
    parameter int BLINK_TICKS   = 8,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  vsync_pulse,
    input  logic                  spawn,
    input  logic [2:0]            spawn_type,
    input  logic                  collect,
    input  logic                  despawn,
    input  logic                  hit,
    output logic [2:0]            s_type,
    output logic [LOG_FRAMES-1:0] frame,
    output logic                  active,
    output logic                  collecting,
    output logic                  heart_frame,
    output logic                  blinking
);

    localparam int TICK_MAX = (TICKS_PER_FRM > COLLECT_TICKS) ? TICKS_PER_FRM - 1 : COLLECT_TICKS - 1;
    localparam int TICK_W   = $clog2(TICK_MAX) + 1;
    localparam int HTICK_W  = $clog2(BLINK_TICKS - 1) + 1;
    localparam int BCNT_W   = $clog2(BLINK_TOGGLES) + 1;

    typedef enum logic [1:0] {IDLE, SWIM, COLL} state_t;

    state_t                state, state_nxt;
    logic [TICK_W-1:0]     tick_cnt, tick_nxt;
    logic [LOG_FRAMES-1:0] frame_nxt;
    logic [2:0]            s_type_nxt;
    logic [HTICK_W-1:0]    tick_cnt_h;
    logic [BCNT_W-1:0]     blink_cnt;

    wire swim_step    = (tick_cnt == TICK_W'(TICKS_PER_FRM - 1));
    wire collect_done = (tick_cnt == TICK_W'(COLLECT_TICKS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            frame      <= '0;
            s_type     <= '0;
            active     <= 1'b0;
            collecting <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_nxt;
            frame      <= frame_nxt;
            s_type     <= s_type_nxt;
            active     <= (state_nxt != IDLE);
            collecting <= (state_nxt == COLL);
        end
    end

    // Priority: despawn > collect > vsync tick > spawn
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (spawn) state_nxt = SWIM;
            SWIM: begin
                if (despawn)      state_nxt = IDLE;
                else if (collect) state_nxt = COLL;
            end
            COLL: begin
                if (despawn)                          state_nxt = IDLE;
                else if (vsync_pulse && collect_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tick_nxt   = tick_cnt;
        frame_nxt  = frame;
        s_type_nxt = s_type;
        case (state)
            IDLE: begin
                if (spawn) begin
                    s_type_nxt = spawn_type;
                    frame_nxt  = '0;
                    tick_nxt   = '0;
                end
            end
            SWIM: begin
                if (despawn) begin
                    s_type_nxt = '0;
                    frame_nxt  = '0;
                    tick_nxt   = '0;
                end else if (collect) begin
                    frame_nxt = LOG_FRAMES'(COLLECT_FRAME);
                    tick_nxt  = '0;
                end else if (vsync_pulse) begin
                    if (swim_step) begin
                        tick_nxt  = '0;
                        frame_nxt = (frame == LOG_FRAMES'(SWIM_FRAMES - 1)) ? '0 : frame + LOG_FRAMES'(1);
                    end else begin
                        tick_nxt = tick_cnt + TICK_W'(1);
                    end
                end
            end
            COLL: begin
                if (despawn || (vsync_pulse && collect_done)) begin
                    s_type_nxt = '0;
                    frame_nxt  = '0;
                    tick_nxt   = '0;
                end else if (vsync_pulse) begin
                    tick_nxt = tick_cnt + TICK_W'(1);
                end
            end
            default: begin
                s_type_nxt = '0;
                frame_nxt  = '0;
                tick_nxt   = '0;
            end
        endcase
    end

    // Heart blink: the last toggle is forced to the full heart so the icon always ends solid
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            tick_cnt_h  <= '0;
            heart_frame <= 1'b0;
            blinking    <= 1'b0;
        end else if (hit) begin
            blink_cnt   <= BCNT_W'(BLINK_TOGGLES);
            tick_cnt_h  <= '0;
            heart_frame <= 1'b1;
            blinking    <= 1'b1;
        end else if (blinking && vsync_pulse) begin
            if (tick_cnt_h == HTICK_W'(BLINK_TICKS - 1)) begin
                tick_cnt_h <= '0;
                blink_cnt  <= blink_cnt - BCNT_W'(1);
                if (blink_cnt == BCNT_W'(1)) begin
                    blinking    <= 1'b0;
                    heart_frame <= 1'b0;
                end else begin
                    heart_frame <= ~heart_frame;
                end
            end else begin
                tick_cnt_h <= tick_cnt_h + HTICK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Bench for sprite_anim_ctrl: directed scenarios plus random pulses against
// a vsync-counting reference model.
module tb_sprite_anim_ctrl;

    localparam int LF = 3, SW = 4, TPF = 6, CF = 4, CT = 20, BT = 8, BTOG = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          vsync_pulse = 1'b0, spawn = 1'b0, collect = 1'b0, despawn = 1'b0, hit = 1'b0;
    logic [2:0]    spawn_type = 3'd0;
    logic [2:0]    s_type;
    logic [LF-1:0] frame;
    logic          active, collecting, heart_frame, blinking;

    int n_tests = 0;
    int n_fail  = 0;

    // model: sprite phase (0 idle, 1 swim, 2 collect) and vsyncs counted in that phase
    int m_st, m_type, m_cnt, m_hcnt;
    bit m_hb;

    sprite_anim_ctrl dut (
        .clock(clock), .reset(reset), .vsync_pulse(vsync_pulse), .spawn(spawn),
        .spawn_type(spawn_type), .collect(collect), .despawn(despawn), .hit(hit),
        .s_type(s_type), .frame(frame), .active(active), .collecting(collecting),
        .heart_frame(heart_frame), .blinking(blinking)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_st = 0; m_type = 0; m_cnt = 0; m_hcnt = 0; m_hb = 1'b0;
    endfunction

    function automatic void model_step();
        if (m_st != 0 && despawn) begin
            m_st = 0; m_type = 0;
        end else if (m_st == 1 && collect) begin
            m_st = 2; m_cnt = 0;
        end else if (m_st != 0 && vsync_pulse) begin
            m_cnt++;
            if (m_st == 2 && m_cnt == CT) begin
                m_st = 0; m_type = 0;
            end
        end else if (m_st == 0 && spawn) begin
            m_st = 1; m_cnt = 0; m_type = int'(spawn_type);
        end
        if (hit) begin
            m_hb = 1'b1; m_hcnt = 0;
        end else if (m_hb && vsync_pulse) begin
            m_hcnt++;
            if (m_hcnt == BT * BTOG) m_hb = 1'b0;
        end
    endfunction

    function automatic logic [7:0] exp_spr();
        int f;
        f = (m_st == 1) ? (m_cnt / TPF) % SW : (m_st == 2) ? CF : 0;
        return {3'(m_type), 3'(f), m_st != 0, m_st == 2};
    endfunction

    function automatic logic [1:0] exp_hrt();
        logic hf;
        hf = m_hb ? ((m_hcnt / BT) % 2 == 0) : 1'b0;
        return {hf, m_hb};
    endfunction

    task automatic cmp_model();
        chk("sprite", {24'd0, s_type, frame, active, collecting}, {24'd0, exp_spr()});
        chk("heart", {30'd0, heart_frame, blinking}, {30'd0, exp_hrt()});
    endtask

    task automatic cyc(input logic v, input logic sp, input logic [2:0] st,
                       input logic co, input logic de, input logic hi);
        vsync_pulse = v; spawn = sp; spawn_type = st; collect = co; despawn = de; hit = hi;
        @(posedge clock);
        if (reset) model_reset();
        else model_step();
        #1;
        cmp_model();
    endtask

    task automatic vs(input int n);
        repeat (n) begin
            cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic async_reset_check(input string tag);
        #2 reset = 1'b1;
        #1;
        chk(tag, {24'd0, s_type, frame, active, collecting, heart_frame, blinking}, 32'd0);
        model_reset();
    endtask

    initial begin
        model_reset();
        // reset held with random pulses
        repeat (8) cyc(1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        chk("rst_held", {24'd0, s_type, frame, active, collecting, heart_frame, blinking}, 32'd0);
        reset = 1'b0;
        idle(5);
        chk("rst_quiet", {24'd0, s_type, frame, active, collecting, heart_frame, blinking}, 32'd0);

        // spawn and swim cycle
        cyc(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        chk("t2_spawn", {29'd0, s_type, frame, active}, {29'd0, 3'd1, 3'd0, 1'b1});
        vs(6);
        chk("t2_frame1", 32'(frame), 32'd1);
        vs(18);
        chk("t2_wrap", 32'(frame), 32'd0);

        // collect pose
        vs(12);
        chk("t3_frame2", 32'(frame), 32'd2);
        cyc(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        chk("t3_collect", {28'd0, frame, collecting}, {28'd0, 3'd4, 1'b1});
        vs(19);
        chk("t3_still", 32'(collecting), 32'd1);
        vs(1);
        chk("t3_exit", {28'd0, s_type, active}, 32'd0);

        // same-cycle priorities
        cyc(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        chk("t4_despawn_wins", {30'd0, active, collecting}, 32'd0);
        cyc(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
        chk("t4_spawn_ignored", 32'(s_type), 32'd3);
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        idle(1);
        vs(19);
        chk("t4_cv_still", 32'(collecting), 32'd1);
        cyc(1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
        chk("t4_cv_exit_spawn", {29'd0, s_type, active}, 32'd0);

        // heart blink and restart
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("t5_hit", {30'd0, heart_frame, blinking}, 32'd3);
        vs(8);
        chk("t5_toggle", {30'd0, heart_frame, blinking}, 32'd1);
        vs(40);
        chk("t5_end", {30'd0, heart_frame, blinking}, 32'd0);
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        vs(20);
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("t5_rehit", {30'd0, heart_frame, blinking}, 32'd3);
        idle(1);
        vs(47);
        chk("t5_re_still", 32'(blinking), 32'd1);
        vs(1);
        chk("t5_re_end", {30'd0, heart_frame, blinking}, 32'd0);

        // async reset mid-collect and mid-blink
        cyc(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
        vs(3);
        async_reset_check("t6_async");
        idle(2);
        reset = 1'b0;
        idle(1);
        cyc(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        chk("t6_respawn", {29'd0, s_type, frame, active}, {29'd0, 3'd1, 3'd0, 1'b1});
        vs(6);
        chk("t6_frame1", 32'(frame), 32'd1);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                async_reset_check("rnd_async");
                idle(1);
                reset = 1'b0;
            end
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, 3'($urandom),
                $urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
